tcp_hdr_scheduler: RTL
======================

// Module: tcp_hdr_scheduler
// PURPOSE
//  Successor to the single-mode SYN header builder. Round-robin scans the connection table for records needing a segment.
//  Decodes each record's state into a SYN, ACK or FIN|ACK segment and assembles the 54-byte Eth/IPv4/TCP header.
//  Offers the header downstream on a valid/ready handshake, then writes the record's next state back to the table.
//  Sits between the connection table RAM and the checksum/transmit stage.
// PARAMETERS
//  ADDR_W      8        table address width
//  REC_STRIDE  10       words per connection record
//  NUM_REC     25       records in table; last base = (NUM_REC-1)*REC_STRIDE
//  WIN_SIZE    16'h3908 advertised TCP window
//  IP_TTL      8'h40    IPv4 time-to-live
// PORTS
//  clk        in   1       clock
//  rst        in   1       reset, asynchronous, active-high
//  enable     in   1       scan enable
//  tbl_addr   out  ADDR_W  table read/write address
//  tbl_rdata  in   32      table read data, 2-cycle latency from tbl_addr
//  tbl_wdata  out  32      write-back data
//  tbl_wren   out  1       write strobe
//  header     out  432     [431:384] dst MAC; [383:336] src MAC; [335:0] as rest of wire order
//  hdr_valid  out  1       header valid
//  hdr_ready  in   1       downstream accepts header
//  rec_base   out  ADDR_W  base address of record being serviced
// BEHAVIOUR
//  Record words, relative to base:
//   - 0: {valid, state[30:0]}
//   - 1: seq; 2: ack; 3: ip_src; 4: ip_dst
//   - 5: smac[47:16]; 6: smac[15:0] in [31:16]
//   - 7: dmac[47:16]; 8: dmac[15:0] in [31:16]
//   - 9: {sport, dport}
//  State actions (action -> flags, written-back state):
//   - CLOSED=1 -> SYN 9'h002, write SENT_SYN=2
//   - ACK_PEND=3 -> ACK 9'h010, write ESTAB=4
//   - CLOSE_REQ=5 -> FIN|ACK 9'h011, write FIN_WAIT1=6
//   - Any other state, or valid=0 -> skip record
//  FSM:
//   - IDLE -> REQ when enable
//   - REQ (addr=base) -> WAIT -> CHECK
//   - CHECK: action -> FETCH; else advance base, -> REQ (-> IDLE if !enable)
//   - FETCH: addresses base+1..base+9 issued on 9 consecutive cycles; each word captured 2 cycles after issue; 11 cycles total -> OFFER
//   - OFFER: hdr_valid=1 until hdr_valid&&hdr_ready -> WB
//   - WB: tbl_wren=1 for 1 cycle, tbl_addr=base, tbl_wdata={1'b1,next_state}; advance base; -> REQ if enable else IDLE
//  Latency: hdr_valid first high exactly 14 cycles after entering REQ for an actionable record.
//  Base advance: base+REC_STRIDE; wraps to 0 after last base. No skipped or repeated records.
//  Fixed header fields:
//   - eth_type 16'h0800; ver/ihl 8'h45; tos 8'h10; ip_len 16'd40
//   - ip_id 0; flags 3'b010, frag 0; ttl IP_TTL; proto 8'h06
//   - tcp data offset 4'h5, reserved 0; window WIN_SIZE; urgent 0; tcp_checksum 0
//   - ack field = word 2 when ACK flag set, else 32'h0
//  Handshake:
//   - header stable while hdr_valid=1
//   - hdr_ready high in the cycle hdr_valid rises completes the transfer that cycle
//   - hdr_ready is ignored when hdr_valid=0
//  enable dropped mid-record: the current record completes, including WB, then IDLE.
//  Reset (any time, incl. mid-FETCH/OFFER/WB):
//   - state=IDLE; base=0; header=0
//   - hdr_valid=0, tbl_wren=0, tbl_wdata=0, tbl_addr=0
//   - no write-back of the interrupted record
// CONFIGURATION
//  HDR_IP_CSUM_EN defined:
//   - extra CSUM state between FETCH and OFFER (+1 cycle latency, 15 total)
//   - header[239:224] = ones-complement of folded 16-bit sum of the 10 IP header halfwords
//  HDR_IP_CSUM_EN undefined: header[239:224]=16'h0000, filled downstream.
// TESTING
//  - Reset, record 0 = {1,1}, ip 0xC0A80001->0xC0A80002, hdr_ready=1 -> hdr_valid at cycle 14; flags 9'h002; one write addr 0 data 32'h80000002.
//  - Record 10 state 3, ack word 32'h12345678 -> header[95:64]=32'h12345678, flags 9'h010, write-back 32'h80000004 at addr 10.
//  - Only record 240 actionable (state 5) -> services base 240, then wraps to base 0; flags 9'h011.
//  - hdr_ready low 20 cycles in OFFER -> hdr_valid held and header unchanged; tbl_wren only after accept.
//  - rst asserted mid-FETCH -> outputs 0 immediately; no tbl_wren; rescan restarts at base 0.
//  - HDR_IP_CSUM_EN, first-scenario addresses -> header[239:224]=16'hB96C; hdr_valid at cycle 15.

Source files
------------

// File: rtl/tcp_hdr_scheduler.sv
// tcp_hdr_scheduler
//  Round-robin scanner over a connection table. For each record whose state
//  calls for a segment (SYN, ACK or FIN|ACK), it fetches the record, builds the
//  54-byte Ethernet/IPv4/TCP header, offers it on a valid/ready handshake, and
//  then writes the record's next state back to the table.
//  Build option: define HDR_IP_CSUM_EN to compute the IPv4 header checksum in
//  an extra CSUM state. Without it, header[239:224] is left zero and is filled
//  in downstream.
module tcp_hdr_scheduler #(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned REC_STRIDE = 10,
   parameter int unsigned NUM_REC    = 25,
   parameter logic [15:0] WIN_SIZE   = 16'h3908,
   parameter logic [7:0]  IP_TTL     = 8'h40
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   output logic [ADDR_W-1:0] tbl_addr,
   input  logic [31:0]       tbl_rdata,
   output logic [31:0]       tbl_wdata,
   output logic              tbl_wren,
   output logic [431:0]      header,
   output logic              hdr_valid,
   input  logic              hdr_ready,
   output logic [ADDR_W-1:0] rec_base
);

   localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'((NUM_REC - 1) * REC_STRIDE);
   localparam logic [ADDR_W-1:0] STRIDE     = ADDR_W'(REC_STRIDE);
   // Fetch issues words 1..9 on counts 0..8; the last word lands on count 10.
   localparam logic [3:0]        FETCH_LAST = 4'd10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CHECK,
      S_FETCH,
      S_CSUM,
      S_OFFER,
      S_WB
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        fetch_cnt_q, fetch_cnt_d;
   logic [431:0]      header_q;
   logic [30:0]       next_st_q;
   logic              ack_sel_q;

   logic              act_valid;
   logic [8:0]        act_flags;
   logic [30:0]       act_next;
   logic [431:0]      hdr_fixed;
   logic [ADDR_W-1:0] base_adv;

   assign header   = header_q;
   assign rec_base = base_q;
   assign base_adv = (base_q == LAST_BASE) ? '0 : base_q + STRIDE;

   // Decode record word 0 (as presented in CHECK) into the segment to send.
   always_comb begin
      act_valid = 1'b0;
      act_flags = 9'h000;
      act_next  = 31'd0;
      if (tbl_rdata[31]) begin
         case (tbl_rdata[30:0])
            31'd1: begin
               act_valid = 1'b1;
               act_flags = 9'h002;
               act_next  = 31'd2;
            end
            31'd3: begin
               act_valid = 1'b1;
               act_flags = 9'h010;
               act_next  = 31'd4;
            end
            31'd5: begin
               act_valid = 1'b1;
               act_flags = 9'h011;
               act_next  = 31'd6;
            end
            default: begin
               act_valid = 1'b0;
            end
         endcase
      end
   end

   // Constant header fields plus the decoded TCP flags; the per-record fields
   // are filled in word by word during FETCH.
   always_comb begin
      hdr_fixed            = '0;
      hdr_fixed[335:320]   = 16'h0800;
      hdr_fixed[319:312]   = 8'h45;
      hdr_fixed[311:304]   = 8'h10;
      hdr_fixed[303:288]   = 16'd40;
      hdr_fixed[287:272]   = 16'h0000;
      hdr_fixed[271:256]   = {3'b010, 13'd0};
      hdr_fixed[255:248]   = IP_TTL;
      hdr_fixed[247:240]   = 8'h06;
      hdr_fixed[63:60]     = 4'h5;
      hdr_fixed[59:57]     = 3'b000;
      hdr_fixed[56:48]     = act_flags;
      hdr_fixed[47:32]     = WIN_SIZE;
   end

`ifdef HDR_IP_CSUM_EN
   // IPv4 header checksum over the ten halfwords of header[319:160]; the
   // checksum slot itself is still zero while this is evaluated.
   logic [15:0] ip_hw [10];
   logic [19:0] ip_sum;
   logic [16:0] ip_fold;
   logic [15:0] ip_csum;
   genvar gi;
   for (gi = 0; gi < 10; gi++) begin : g_ip_hw
      assign ip_hw[gi] = header_q[319 - 16*gi -: 16];
   end

   // Sum, fold the carries back in, and complement.
   always_comb begin
      ip_sum = 20'd0;
      for (int i = 0; i < 10; i++) begin
         ip_sum = ip_sum + 20'(ip_hw[i]);
      end
      ip_fold = 17'(ip_sum[15:0]) + 17'(ip_sum[19:16]);
      ip_csum = ~(ip_fold[15:0] + 16'(ip_fold[16]));
   end
`endif

   // FSM state, record base and fetch counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         fetch_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Next-state logic and table/handshake outputs.
   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      fetch_cnt_d = fetch_cnt_q;
      tbl_addr    = '0;
      tbl_wren    = 1'b0;
      tbl_wdata   = 32'h0;
      hdr_valid   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_REQ;
         end
         S_REQ: begin
            tbl_addr = base_q;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_CHECK;
         end
         S_CHECK: begin
            fetch_cnt_d = 4'd0;
            if (act_valid) begin
               state_d = S_FETCH;
            end else begin
               base_d  = base_adv;
               state_d = enable ? S_REQ : S_IDLE;
            end
         end
         S_FETCH: begin
            if (fetch_cnt_q <= 4'd8) begin
               tbl_addr = base_q + ADDR_W'(fetch_cnt_q) + ADDR_W'(1);
            end
            fetch_cnt_d = fetch_cnt_q + 4'd1;
            if (fetch_cnt_q == FETCH_LAST) begin
`ifdef HDR_IP_CSUM_EN
               state_d = S_CSUM;
`else
               state_d = S_OFFER;
`endif
            end
         end
         S_CSUM: begin
            state_d = S_OFFER;
         end
         S_OFFER: begin
            hdr_valid = 1'b1;
            if (hdr_ready) state_d = S_WB;
         end
         S_WB: begin
            tbl_wren  = 1'b1;
            tbl_addr  = base_q;
            tbl_wdata = {1'b1, next_st_q};
            base_d    = base_adv;
            state_d   = enable ? S_REQ : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Header assembly: fixed fields at CHECK, record words as they return.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         header_q  <= '0;
         next_st_q <= 31'd0;
         ack_sel_q <= 1'b0;
      end else begin
         case (state_q)
            S_CHECK: begin
               if (act_valid) begin
                  header_q  <= hdr_fixed;
                  next_st_q <= act_next;
                  ack_sel_q <= act_flags[4];
               end
            end
            S_FETCH: begin
               case (fetch_cnt_q)
                  4'd2:  header_q[127:96]  <= tbl_rdata;
                  4'd3:  header_q[95:64]   <= ack_sel_q ? tbl_rdata : 32'h0;
                  4'd4:  header_q[223:192] <= tbl_rdata;
                  4'd5:  header_q[191:160] <= tbl_rdata;
                  4'd6:  header_q[383:352] <= tbl_rdata;
                  4'd7:  header_q[351:336] <= tbl_rdata[31:16];
                  4'd8:  header_q[431:400] <= tbl_rdata;
                  4'd9:  header_q[399:384] <= tbl_rdata[31:16];
                  4'd10: header_q[159:128] <= tbl_rdata;
                  default: begin
                  end
               endcase
            end
`ifdef HDR_IP_CSUM_EN
            S_CSUM: begin
               header_q[239:224] <= ip_csum;
            end
`endif
            default: begin
            end
         endcase
      end
   end

endmodule
